// File: rtl/switch_bounce_emulator_if.sv
// Control/status bundle between test-control logic and the bounce emulator.
// The master drives the requested level and reads back the noisy switch and event status.
interface switch_bounce_emulator_if;
    logic       enable;
    logic       level_in;
    logic       switch_out;
    logic       busy;
    logic       done;
    logic [7:0] toggle_cnt;

    modport master (
        output enable,
        output level_in,
        input  switch_out,
        input  busy,
        input  done,
        input  toggle_cnt
    );

    modport slave (
        input  enable,
        input  level_in,
        output switch_out,
        output busy,
        output done,
        output toggle_cnt
    );
endinterface

// File: rtl/switch_bounce_emulator.sv
// Mechanical-switch bounce source: turns a clean level request into a burst of
// pseudo-random toggles on a tick timebase, then holds the requested level.
module switch_bounce_emulator #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned GAP_W        = 3,
    parameter int unsigned N_TOGGLES    = 5,
    parameter int unsigned SETTLE_TICKS = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic                     clk,
    input logic                     reset,
    switch_bounce_emulator_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned GAPC_W = GAP_W + 1;
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [15:0]         r_lfsr;
    logic                r_target;
    logic [7:0]          r_toggles_left;
    logic [GAPC_W-1:0]   r_gap;
    logic [7:0]          r_settle_cnt;
    logic                r_switch_out;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_toggle_cnt;

    logic                w_tick;
    logic                w_lfsr_fb;
    logic [GAPC_W-1:0]   w_gap_load;
    logic                w_mismatch;
    logic                w_target;
    logic [7:0]          w_toggles_left;
    logic [GAPC_W-1:0]   w_gap;
    logic [7:0]          w_settle_cnt;
    logic                w_switch_out;
    logic                w_busy;
    logic                w_done;
    logic [7:0]          w_toggle_cnt;

    assign w_tick     = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_gap_load = GAPC_W'(r_lfsr[GAP_W-1:0]) + GAPC_W'(1);
    assign w_mismatch = (bus.level_in != r_switch_out);

    // Free-running tick timebase and gap randomiser, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_lfsr     <= SEED;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_tick) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_target       <= 1'b0;
            r_toggles_left <= '0;
            r_gap          <= '0;
            r_settle_cnt   <= '0;
            r_switch_out   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_toggle_cnt   <= '0;
        end else begin
            r_state        <= w_next_state;
            r_target       <= w_target;
            r_toggles_left <= w_toggles_left;
            r_gap          <= w_gap;
            r_settle_cnt   <= w_settle_cnt;
            r_switch_out   <= w_switch_out;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_toggle_cnt   <= w_toggle_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!bus.enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_mismatch) w_next_state = (N_TOGGLES == 0) ? S_SETTLE : S_BOUNCE;
                S_BOUNCE: if (w_tick && r_gap == GAPC_W'(1) && r_toggles_left == 8'd1) w_next_state = S_SETTLE;
                S_SETTLE: if (w_tick && r_settle_cnt == 8'd1) w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Bypass mirrors level_in with one cycle of latency and abandons any event silently.
    always_comb begin
        w_target       = r_target;
        w_toggles_left = r_toggles_left;
        w_gap          = r_gap;
        w_settle_cnt   = r_settle_cnt;
        w_switch_out   = r_switch_out;
        w_busy         = r_busy;
        w_done         = 1'b0;
        w_toggle_cnt   = r_toggle_cnt;
        if (!bus.enable) begin
            w_switch_out = bus.level_in;
            w_busy       = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mismatch) begin
                        w_target       = bus.level_in;
                        w_toggle_cnt   = '0;
                        w_busy         = 1'b1;
                        w_toggles_left = 8'(N_TOGGLES);
                        w_gap          = w_gap_load;
                        if (N_TOGGLES == 0) begin
                            w_switch_out = bus.level_in;
                            w_settle_cnt = 8'(SETTLE_TICKS);
                        end
                    end
                end
                S_BOUNCE: begin
                    if (w_tick) begin
                        if (r_gap == GAPC_W'(1)) begin
                            w_switch_out   = ~r_switch_out;
                            w_toggle_cnt   = r_toggle_cnt + 8'd1;
                            w_toggles_left = r_toggles_left - 8'd1;
                            w_gap          = w_gap_load;
                            if (r_toggles_left == 8'd1) begin
                                w_settle_cnt = 8'(SETTLE_TICKS);
                            end
                        end else begin
                            w_gap = r_gap - GAPC_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    // Forcing the target here fixes the final level when the toggle count is even.
                    w_switch_out = r_target;
                    if (w_tick) begin
                        w_settle_cnt = r_settle_cnt - 8'd1;
                        if (r_settle_cnt == 8'd1) begin
                            w_done = 1'b1;
                            w_busy = 1'b0;
                        end
                    end
                end
                default: begin
                    w_busy = 1'b0;
                end
            endcase
        end
    end

    assign bus.switch_out = r_switch_out;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Scoreboard bench: two emulators (odd and even toggle counts) with a done-driven
// monitor per instance, plus a slow 3-sample debouncer on instance 0.
module tb_switch_bounce_emulator;

    typedef struct {
        logic       lvl;
        logic [7:0] cnt;
        int         edges;
        int         hold;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en[2];
    logic lvl[2];
    logic sw[2];
    logic busy[2];
    logic done[2];
    logic [7:0] tcnt[2];

    exp_t exp_q[2][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_spacing(input int d);
        n_tests++;
        if (d < 4 || d > 32 || (d % 4) != 0) begin
            n_fail++;
            $display("FAIL edge_spacing: got %0d clk, expected a multiple of 4 in 4..32", d);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NTOG = (g == 0) ? 5 : 4;

        switch_bounce_emulator_if u_if ();

        switch_bounce_emulator #(
            .TICK_DIV     (4),
            .GAP_W        (3),
            .N_TOGGLES    (NTOG),
            .SETTLE_TICKS (8),
            .LFSR_SEED    ((g == 0) ? 16'hACE1 : 16'h1234)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (u_if)
        );

        assign u_if.enable   = en[g];
        assign u_if.level_in = lvl[g];
        assign sw[g]         = u_if.switch_out;
        assign busy[g]       = u_if.busy;
        assign done[g]       = u_if.done;
        assign tcnt[g]       = u_if.toggle_cnt;

        int   edge_cnt  = 0;
        int   last_edge = 0;
        logic prev_sw   = 1'b0;
        logic prev_busy = 1'b0;

        // Monitor: tracks switch edges per event and retires one scoreboard entry per done.
        always @(negedge clk) begin : mon
            exp_t e;
            if (reset) begin
                edge_cnt  = 0;
                prev_sw   = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (busy[g] && !prev_busy) edge_cnt = 0;
                if (sw[g] !== prev_sw) begin
                    edge_cnt++;
                    if (busy[g] && edge_cnt >= 2 && edge_cnt <= NTOG) check_spacing(cyc - last_edge);
                    last_edge = cyc;
                end
                if (done[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("spurious_done%0d", g), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("done_level%0d", g), 32'(sw[g]), 32'(e.lvl));
                        check($sformatf("done_toggle_cnt%0d", g), 32'(tcnt[g]), 32'(e.cnt));
                        check($sformatf("done_busy%0d", g), 32'(busy[g]), 32'd0);
                        check($sformatf("event_edges%0d", g), 32'(edge_cnt), 32'(e.edges));
                        check($sformatf("settle_hold%0d", g), 32'(cyc - last_edge), 32'(e.hold));
                    end
                end
                prev_sw   = sw[g];
                prev_busy = busy[g];
            end
        end
    end

    // Downstream consumer: 3 agreeing samples taken every 16 clk.
    logic [2:0] db_sh    = 3'b000;
    logic       db       = 1'b0;
    logic       db_prev  = 1'b0;
    int         db_div   = 0;
    int         db_trans = 0;

    always @(posedge clk) begin
        if (reset) begin
            db_sh  <= 3'b000;
            db     <= 1'b0;
            db_div <= 0;
        end else begin
            db_div <= (db_div == 15) ? 0 : db_div + 1;
            if (db_div == 15) begin
                db_sh <= {db_sh[1:0], sw[0]};
                if ({db_sh[1:0], sw[0]} == 3'b111) db <= 1'b1;
                else if ({db_sh[1:0], sw[0]} == 3'b000) db <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && db !== db_prev) db_trans++;
        db_prev = db;
    end

    task automatic drive_lvl(input int idx, input logic v);
        @(posedge clk);
        #1 lvl[idx] = v;
    endtask

    task automatic wait_done(input int idx, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[idx] && n < budget);
        check($sformatf("done_seen%0d", idx), 32'(done[idx]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   act;
        int   base;
        logic cur;
        logic vec[10];
        vec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        en[0] = 1'b1; en[1] = 1'b1; lvl[0] = 1'b0; lvl[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_switch_out", 32'(sw[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_done", 32'(done[i]), 32'd0);
            check("reset_toggle_cnt", 32'(tcnt[i]), 32'd0);
        end

        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (sw[0] || busy[0] || done[0]) act++;
        end
        check("idle_activity", 32'(act), 32'd0);

        // Rising event, odd toggle count.
        exp_q[0].push_back('{lvl: 1'b1, cnt: 8'd5, edges: 5, hold: 32});
        drive_lvl(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_start", 32'(busy[0]), 32'd1);
        wait_done(0, 400);
        @(negedge clk);
        check("done_pulse_width", 32'(done[0]), 32'd0);

        // Falling event.
        exp_q[0].push_back('{lvl: 1'b0, cnt: 8'd5, edges: 5, hold: 32});
        drive_lvl(0, 1'b0);
        wait_done(0, 400);

        // Request reverts mid-bounce: first event completes, second follows immediately.
        exp_q[0].push_back('{lvl: 1'b1, cnt: 8'd5, edges: 5, hold: 32});
        exp_q[0].push_back('{lvl: 1'b0, cnt: 8'd5, edges: 5, hold: 32});
        drive_lvl(0, 1'b1);
        repeat (8) @(negedge clk);
        drive_lvl(0, 1'b0);
        @(negedge clk);
        check("busy_ignores_change", 32'(busy[0]), 32'd1);
        wait_done(0, 400);
        @(negedge clk);
        check("restart_after_done", 32'(busy[0]), 32'd1);
        wait_done(0, 400);
        @(negedge clk);
        check("mid_event_final", 32'(sw[0]), 32'd0);

        // Abort by bypass mid-bounce, then follow level_in with one cycle of latency.
        drive_lvl(0, 1'b1);
        repeat (8) @(negedge clk);
        check("abort_busy_before", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1 en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_after", 32'(busy[0]), 32'd0);
        check("bypass_level", 32'(sw[0]), 32'd1);
        drive_lvl(0, 1'b0);
        @(negedge clk);
        check("bypass_latency_old", 32'(sw[0]), 32'd1);
        @(negedge clk);
        check("bypass_follow_low", 32'(sw[0]), 32'd0);
        drive_lvl(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("bypass_follow_high", 32'(sw[0]), 32'd1);
        drive_lvl(0, 1'b0);
        repeat (60) @(negedge clk);
        check("bypass_final", 32'(sw[0]), 32'd0);
        check("bypass_no_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1 en[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("reenable_quiet", 32'(busy[0]), 32'd0);

        // Even toggle count: four toggles then the settle forcing edge.
        exp_q[1].push_back('{lvl: 1'b1, cnt: 8'd4, edges: 5, hold: 31});
        drive_lvl(1, 1'b1);
        wait_done(1, 400);
        exp_q[1].push_back('{lvl: 1'b0, cnt: 8'd4, edges: 5, hold: 31});
        drive_lvl(1, 1'b0);
        wait_done(1, 400);
        @(negedge clk);
        check("parity_final", 32'(sw[1]), 32'd0);

        // Integration: the debouncer must move once per real event and never on a repeat.
        repeat (100) @(negedge clk);
        check("db_start", 32'(db), 32'd0);
        cur = 1'b0;
        for (int i = 0; i < 10; i++) begin
            base = db_trans;
            drive_lvl(0, vec[i]);
            if (vec[i] != cur) begin
                exp_q[0].push_back('{lvl: vec[i], cnt: 8'd5, edges: 5, hold: 32});
                wait_done(0, 400);
            end
            repeat (80) @(negedge clk);
            check($sformatf("db_level_%0d", i), 32'(db), 32'(vec[i]));
            check($sformatf("db_transitions_%0d", i), 32'(db_trans - base), (vec[i] != cur) ? 32'd1 : 32'd0);
            cur = vec[i];
        end

        repeat (20) @(negedge clk);
        check("pending_events0", 32'(exp_q[0].size()), 32'd0);
        check("pending_events1", 32'(exp_q[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
